// File: rtl/alu_operand_stage_pkg.sv
// Shared processor definitions: ALU opcodes and operand-stage FSM state encoding.
package alu_operand_stage_pkg;

   localparam int unsigned OpWidth = 3;

   localparam logic [OpWidth-1:0] OpAdd    = 3'b000;
   localparam logic [OpWidth-1:0] OpSub    = 3'b001;
   localparam logic [OpWidth-1:0] OpMul    = 3'b010;
   localparam logic [OpWidth-1:0] OpPassA  = 3'b011;
   localparam logic [OpWidth-1:0] OpPassB  = 3'b100;
   localparam logic [OpWidth-1:0] OpClear  = 3'b101;
   localparam logic [OpWidth-1:0] OpFinish = 3'b110;
   localparam logic [OpWidth-1:0] OpNop    = 3'b111;

   typedef enum logic [1:0] {
      StIdle = 2'b00,
      StExec = 2'b01,
      StDone = 2'b10,
      StHalt = 2'b11
   } state_e;

endpackage

// File: rtl/operand_bank.sv
// Operand register bank: one synchronous write port, one combinational read port.
module operand_bank #(
   parameter int unsigned DATA_LEN = 16,
   parameter int unsigned REG_CNT  = 8
) (
   input  logic                       clk_i,
   input  logic                       rst_ni,
   input  logic                       wr_en_i,
   input  logic [$clog2(REG_CNT)-1:0] wr_addr_i,
   input  logic [DATA_LEN-1:0]        wr_data_i,
   input  logic [$clog2(REG_CNT)-1:0] rd_addr_i,
   output logic [DATA_LEN-1:0]        rd_data_o
);

   logic [DATA_LEN-1:0] mem_q [REG_CNT];

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         for (int i = 0; i < int'(REG_CNT); i++) begin
            mem_q[i] <= '0;
         end
      end else if (wr_en_i) begin
         mem_q[wr_addr_i] <= wr_data_i;
      end
   end

   // Reads see pre-edge contents, so a same-edge write is never bypassed.
   assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/alu_operand_stage.sv
// Operand stage: latches opcode and bank operand, holds them for the ALU, captures the result.
module alu_operand_stage
   import alu_operand_stage_pkg::*;
#(
   parameter int unsigned ALU_SIG_LEN = 3,
   parameter int unsigned DATA_LEN    = 16,
   parameter int unsigned REG_CNT     = 8
) (
   input  logic                       clk_i,
   input  logic                       rst_ni,
   input  logic                       req_valid_i,
   output logic                       req_ready_o,
   input  logic [ALU_SIG_LEN-1:0]     req_op_i,
   input  logic [$clog2(REG_CNT)-1:0] req_reg_i,
   input  logic                       wr_en_i,
   input  logic [$clog2(REG_CNT)-1:0] wr_addr_i,
   input  logic [DATA_LEN-1:0]        wr_data_i,
   output logic [DATA_LEN-1:0]        alu_a_o,
   output logic [DATA_LEN-1:0]        alu_b_o,
   output logic [ALU_SIG_LEN-1:0]     alu_sel_o,
   input  logic [DATA_LEN-1:0]        alu_out_i,
   output logic [DATA_LEN-1:0]        ac_o,
   output logic                       z_flag_o,
   output logic                       done_o,
   output logic                       halted_o
);

   state_e                 state_q, state_d;
   logic [DATA_LEN-1:0]    ac_q, ac_d;
   logic                   z_q, z_d;
   logic [DATA_LEN-1:0]    alu_b_q, alu_b_d;
   logic [ALU_SIG_LEN-1:0] alu_sel_q, alu_sel_d;
   logic [DATA_LEN-1:0]    bank_rd_data;

   operand_bank #(
      .DATA_LEN (DATA_LEN),
      .REG_CNT  (REG_CNT)
   ) u_bank (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .wr_en_i   (wr_en_i),
      .wr_addr_i (wr_addr_i),
      .wr_data_i (wr_data_i),
      .rd_addr_i (req_reg_i),
      .rd_data_o (bank_rd_data)
   );

   always_comb begin
      state_d   = state_q;
      ac_d      = ac_q;
      z_d       = z_q;
      alu_b_d   = alu_b_q;
      alu_sel_d = alu_sel_q;
      unique case (state_q)
         StIdle: begin
            if (req_valid_i) begin
               alu_sel_d = req_op_i;
               alu_b_d   = bank_rd_data;
               state_d   = StExec;
            end
         end
         StExec: begin
            case (alu_sel_q)
               ALU_SIG_LEN'(OpAdd), ALU_SIG_LEN'(OpSub): begin
                  ac_d = alu_out_i;
                  z_d  = (alu_out_i == '0);
               end
               ALU_SIG_LEN'(OpMul), ALU_SIG_LEN'(OpPassA), ALU_SIG_LEN'(OpPassB): begin
                  ac_d = alu_out_i;
               end
               ALU_SIG_LEN'(OpClear): ac_d = '0;
               default: ;
            endcase
            state_d = StDone;
         end
         StDone: begin
            state_d = (alu_sel_q == ALU_SIG_LEN'(OpFinish)) ? StHalt : StIdle;
         end
         StHalt: state_d = StHalt;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q   <= StIdle;
         ac_q      <= '0;
         z_q       <= 1'b0;
         alu_b_q   <= '0;
         alu_sel_q <= ALU_SIG_LEN'(OpPassA);
      end else begin
         state_q   <= state_d;
         ac_q      <= ac_d;
         z_q       <= z_d;
         alu_b_q   <= alu_b_d;
         alu_sel_q <= alu_sel_d;
      end
   end

   assign req_ready_o = (state_q == StIdle);
   assign done_o      = (state_q == StDone);
   assign halted_o    = (state_q == StHalt);
   assign alu_a_o     = ac_q;
   assign alu_b_o     = alu_b_q;
   assign alu_sel_o   = alu_sel_q;
   assign ac_o        = ac_q;
   assign z_flag_o    = z_q;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Bench for alu_operand_stage: behavioural ALU plus an operation-level reference model.
module tb_alu_operand_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic [2:0]  req_op;
   logic [2:0]  req_reg;
   logic        wr_en;
   logic [2:0]  wr_addr;
   logic [15:0] wr_data;
   logic [15:0] alu_a, alu_b, alu_out, ac;
   logic [2:0]  alu_sel;
   logic        z_flag, done, halted;

   int n_cmp = 0;
   int n_err = 0;

   // Reference state
   logic [15:0] m_bank [8];
   logic [15:0] m_ac;
   logic        m_z;

   always #5 clk = ~clk;

   alu_operand_stage #(
      .ALU_SIG_LEN (3),
      .DATA_LEN    (16),
      .REG_CNT     (8)
   ) dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .req_valid_i (req_valid),
      .req_ready_o (req_ready),
      .req_op_i    (req_op),
      .req_reg_i   (req_reg),
      .wr_en_i     (wr_en),
      .wr_addr_i   (wr_addr),
      .wr_data_i   (wr_data),
      .alu_a_o     (alu_a),
      .alu_b_o     (alu_b),
      .alu_sel_o   (alu_sel),
      .alu_out_i   (alu_out),
      .ac_o        (ac),
      .z_flag_o    (z_flag),
      .done_o      (done),
      .halted_o    (halted)
   );

   always_comb begin
      alu_out = 16'h0000;
      case (alu_sel)
         3'd0: alu_out = alu_a + alu_b;
         3'd1: alu_out = alu_a - alu_b;
         3'd2: alu_out = alu_a * alu_b;
         3'd3: alu_out = alu_a;
         3'd4: alu_out = alu_b;
         default: alu_out = 16'h0000;
      endcase
   end

   task automatic model_reset();
      for (int i = 0; i < 8; i++) m_bank[i] = 16'h0;
      m_ac = 16'h0;
      m_z  = 1'b0;
   endtask

   // Operation effect from the opcode table, using the bank value seen before the accept edge.
   task automatic model_op(input logic [2:0] op, input logic [2:0] r);
      int unsigned b, a, res;
      a = m_ac;
      b = m_bank[r];
      res = a;
      case (op)
         3'd0: res = (a + b) % 65536;
         3'd1: res = (a + 65536 - b) % 65536;
         3'd2: res = (a * b) % 65536;
         3'd3: res = a;
         3'd4: res = b;
         3'd5: res = 0;
         default: res = a;
      endcase
      if (op == 3'd0 || op == 3'd1) m_z = (res == 0);
      m_ac = res[15:0];
   endtask

   task automatic write_bank(input logic [2:0] a, input logic [15:0] d);
      wr_en = 1'b1; wr_addr = a; wr_data = d;
      @(posedge clk); #1;
      wr_en = 1'b0;
      m_bank[a] = d;
   endtask

   // Issues one request from IDLE, optionally with a bank write on the accept edge.
   task automatic run_op(input logic [2:0] op, input logic [2:0] r,
                         input logic wen, input logic [2:0] wa, input logic [15:0] wd,
                         output logic rdy, output logic d1, output logic d2, output logic d3,
                         output logic [15:0] ac_obs, output logic z_obs);
      model_op(op, r);
      rdy = req_ready;
      req_valid = 1'b1; req_op = op; req_reg = r;
      wr_en = wen; wr_addr = wa; wr_data = wd;
      @(posedge clk); #1;
      req_valid = 1'b0; wr_en = 1'b0;
      if (wen) m_bank[wa] = wd;
      d1 = done;
      @(posedge clk); #1;
      d2 = done; ac_obs = ac; z_obs = z_flag;
      @(posedge clk); #1;
      d3 = done;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      req_valid = 1'b0; req_op = 3'd0; req_reg = 3'd0;
      wr_en = 1'b0; wr_addr = 3'd0; wr_data = 16'h0;
      repeat (2) @(posedge clk);
      #1;
      model_reset();
      n_cmp++;
      if ({ac, z_flag, done, halted, alu_b, alu_sel} !== {16'h0, 1'b0, 1'b0, 1'b0, 16'h0, 3'b011}) begin
         n_err++;
         $display("FAIL reset_outputs: got ac=%h z=%b done=%b halted=%b b=%h sel=%b, want 0/0/0/0/0/011",
                  ac, z_flag, done, halted, alu_b, alu_sel);
      end
      rst_n = 1'b1;
      @(posedge clk); #1;
      n_cmp++;
      if (req_ready !== 1'b1) begin
         n_err++;
         $display("FAIL reset_ready: got %b want 1", req_ready);
      end
   endtask

   task automatic test_basic();
      logic rdy, d1, d2, d3, z; logic [15:0] a;
      write_bank(3'd2, 16'd5);
      write_bank(3'd3, 16'd7);
      write_bank(3'd6, 16'd12);
      run_op(3'd4, 3'd2, 1'b0, 3'd0, 16'h0, rdy, d1, d2, d3, a, z);
      n_cmp++;
      if ({rdy, d1, d2, d3, a} !== {1'b1, 1'b0, 1'b1, 1'b0, 16'd5}) begin
         n_err++;
         $display("FAIL passb_r2: got rdy=%b done=%b%b%b ac=%0d want 1 010 5", rdy, d1, d2, d3, a);
      end
      run_op(3'd0, 3'd3, 1'b0, 3'd0, 16'h0, rdy, d1, d2, d3, a, z);
      n_cmp++;
      if ({d1, d2, d3, a, z} !== {1'b0, 1'b1, 1'b0, 16'd12, 1'b0}) begin
         n_err++;
         $display("FAIL add_r3: got done=%b%b%b ac=%0d z=%b want 010 12 0", d1, d2, d3, a, z);
      end
      run_op(3'd1, 3'd6, 1'b0, 3'd0, 16'h0, rdy, d1, d2, d3, a, z);
      n_cmp++;
      if ({a, z} !== {16'd0, 1'b1}) begin
         n_err++;
         $display("FAIL sub_to_zero: got ac=%0d z=%b want 0 1", a, z);
      end
      run_op(3'd2, 3'd3, 1'b0, 3'd0, 16'h0, rdy, d1, d2, d3, a, z);
      n_cmp++;
      if ({a, z} !== {16'd0, 1'b1}) begin
         n_err++;
         $display("FAIL mul_holds_z: got ac=%0d z=%b want 0 1", a, z);
      end
   endtask

   task automatic test_wrap();
      logic rdy, d1, d2, d3, z; logic [15:0] a;
      write_bank(3'd0, 16'hFFFF);
      write_bank(3'd1, 16'h0001);
      write_bank(3'd5, 16'h0100);
      run_op(3'd4, 3'd0, 1'b0, 3'd0, 16'h0, rdy, d1, d2, d3, a, z);
      run_op(3'd0, 3'd1, 1'b0, 3'd0, 16'h0, rdy, d1, d2, d3, a, z);
      n_cmp++;
      if ({a, z} !== {16'h0000, 1'b1}) begin
         n_err++;
         $display("FAIL add_wrap: got ac=%h z=%b want 0000 1", a, z);
      end
      run_op(3'd4, 3'd5, 1'b0, 3'd0, 16'h0, rdy, d1, d2, d3, a, z);
      run_op(3'd2, 3'd5, 1'b0, 3'd0, 16'h0, rdy, d1, d2, d3, a, z);
      n_cmp++;
      if (a !== 16'h0000) begin
         n_err++;
         $display("FAIL mul_low_bits: got ac=%h want 0000", a);
      end
   endtask

   task automatic test_same_edge_write();
      logic rdy, d1, d2, d3, z; logic [15:0] a;
      write_bank(3'd4, 16'd3);
      run_op(3'd4, 3'd4, 1'b1, 3'd4, 16'd9, rdy, d1, d2, d3, a, z);
      n_cmp++;
      if (a !== 16'd3) begin
         n_err++;
         $display("FAIL no_bypass: got ac=%0d want 3", a);
      end
      run_op(3'd4, 3'd4, 1'b0, 3'd0, 16'h0, rdy, d1, d2, d3, a, z);
      n_cmp++;
      if (a !== 16'd9) begin
         n_err++;
         $display("FAIL write_landed: got ac=%0d want 9", a);
      end
   endtask

   task automatic test_random();
      logic rdy, d1, d2, d3, z, wen; logic [15:0] a;
      logic [2:0] op, r, wa;
      for (int i = 0; i < 60; i++) begin
         if ($urandom_range(0, 2) == 0) write_bank(3'($urandom_range(0, 7)), 16'($urandom));
         op = 3'($urandom_range(0, 7));
         if (op == 3'd6) op = 3'd7;
         r = 3'($urandom_range(0, 7));
         wen = ($urandom_range(0, 3) == 0);
         wa = 3'($urandom_range(0, 7));
         run_op(op, r, wen, wa, 16'($urandom), rdy, d1, d2, d3, a, z);
         n_cmp++;
         if ({rdy, d1, d2, d3, a, z, alu_sel} !== {1'b1, 1'b0, 1'b1, 1'b0, m_ac, m_z, op}) begin
            n_err++;
            $display("FAIL random_op%0d: op=%0d got rdy=%b done=%b%b%b ac=%h z=%b sel=%0d want 1 010 %h %b %0d",
                     i, op, rdy, d1, d2, d3, a, z, alu_sel, m_ac, m_z, op);
         end
      end
   endtask

   task automatic test_finish_halt();
      logic rdy, d1, d2, d3, z, bad; logic [15:0] a, ac_frozen;
      run_op(3'd6, 3'd0, 1'b0, 3'd0, 16'h0, rdy, d1, d2, d3, a, z);
      n_cmp++;
      if ({d1, d2, d3, halted, req_ready, a} !== {1'b0, 1'b1, 1'b0, 1'b1, 1'b0, m_ac}) begin
         n_err++;
         $display("FAIL finish_halt: got done=%b%b%b halted=%b ready=%b ac=%h want 010 1 0 %h",
                  d1, d2, d3, halted, req_ready, a, m_ac);
      end
      ac_frozen = m_ac;
      bad = 1'b0;
      req_valid = 1'b1; req_op = 3'd5; req_reg = 3'd0;
      wr_en = 1'b1; wr_addr = 3'd7; wr_data = 16'h1234;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         wr_en = 1'b0;
         if (ac !== ac_frozen || done !== 1'b0 || halted !== 1'b1 || req_ready !== 1'b0) bad = 1'b1;
      end
      req_valid = 1'b0;
      n_cmp++;
      if (bad !== 1'b0) begin
         n_err++;
         $display("FAIL halt_frozen: got state change while halted, ac=%h want %h", ac, ac_frozen);
      end
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      model_reset();
      n_cmp++;
      if ({ac, z_flag, done, halted, req_ready, alu_b, alu_sel} !==
          {16'h0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0, 3'b011}) begin
         n_err++;
         $display("FAIL halt_reset: got ac=%h z=%b done=%b halted=%b ready=%b b=%h sel=%b want 0 0 0 0 1 0 011",
                  ac, z_flag, done, halted, req_ready, alu_b, alu_sel);
      end
   endtask

   task automatic test_reset_abort();
      logic rdy, d1, d2, d3, z, saw_done; logic [15:0] a;
      write_bank(3'd1, 16'd21);
      run_op(3'd4, 3'd1, 1'b0, 3'd0, 16'h0, rdy, d1, d2, d3, a, z);
      n_cmp++;
      if (a !== 16'd21) begin
         n_err++;
         $display("FAIL abort_setup: got ac=%0d want 21", a);
      end
      req_valid = 1'b1; req_op = 3'd0; req_reg = 3'd1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      model_reset();
      n_cmp++;
      if ({ac, done, req_ready} !== {16'h0, 1'b0, 1'b1}) begin
         n_err++;
         $display("FAIL abort_reset: got ac=%h done=%b ready=%b want 0 0 1", ac, done, req_ready);
      end
      saw_done = 1'b0;
      repeat (3) begin
         @(posedge clk); #1;
         if (done !== 1'b0 || ac !== 16'h0) saw_done = 1'b1;
      end
      n_cmp++;
      if (saw_done !== 1'b0) begin
         n_err++;
         $display("FAIL abort_no_done: got done/capture after reset, ac=%h want none", ac);
      end
   endtask

   initial begin
      rst_n = 1'b0;
      req_valid = 1'b0; req_op = 3'd0; req_reg = 3'd0;
      wr_en = 1'b0; wr_addr = 3'd0; wr_data = 16'h0;
      test_reset();
      test_basic();
      test_wrap();
      test_same_edge_write();
      test_random();
      test_finish_halt();
      test_reset_abort();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
